// File: rtl/alu_flag_unit_if.sv
// ALU / flag-bank connection bundle: operation select, operands, flag write
// enables, jump select and all ALU, carry, flag and jump outputs.
interface alu_flag_unit_if #(
    parameter int unsigned WIDTH = 16
);
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m_we;
    logic             z_we;
    logic             o_we;
    logic             c_we;
    logic [1:0]       jump_sel;
    logic             jump_pol;

    logic [WIDTH-1:0] result;
    logic             carry_second_last;
    logic             carry_last;
    logic             zero_next;
    logic             ovf_next;
    logic             flag_m;
    logic             flag_z;
    logic             flag_o;
    logic             flag_c;
    logic             flag_m_n;
    logic             flag_z_n;
    logic             flag_o_n;
    logic             flag_c_n;
    logic             jump_true;

    // Controller / datapath side that issues operations.
    modport master (
        output alu_ctrl, a, b, m_we, z_we, o_we, c_we, jump_sel, jump_pol,
        input  result, carry_second_last, carry_last, zero_next, ovf_next,
        input  flag_m, flag_z, flag_o, flag_c,
        input  flag_m_n, flag_z_n, flag_o_n, flag_c_n, jump_true
    );

    // The ALU and flag bank itself.
    modport slave (
        input  alu_ctrl, a, b, m_we, z_we, o_we, c_we, jump_sel, jump_pol,
        output result, carry_second_last, carry_last, zero_next, ovf_next,
        output flag_m, flag_z, flag_o, flag_c,
        output flag_m_n, flag_z_n, flag_o_n, flag_c_n, jump_true
    );
endinterface

// File: rtl/alu_flag_unit.sv
// Combinational ALU with a registered M/Z/O/C flag bank and conditional-jump
// evaluation. Operand A is the T register, operand B is Bus_1; the result goes
// to Bus_2 through an external tri-state buffer.
module alu_flag_unit #(
    parameter int unsigned WIDTH = 16
) (
    input logic           clk,
    input logic           reset,
    alu_flag_unit_if.slave bus
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] low_sum;
    logic [1:0]       top_sum;
    logic [WIDTH-1:0] arith_sum;
    logic             c_into_msb;

    logic [WIDTH-1:0] result;
    logic             carry_second_last;
    logic             carry_last;
    logic             zero_next;
    logic             ovf_next;

    logic flag_m_q, flag_z_q, flag_o_q, flag_c_q;
    logic sel_flag;

    // Adder split at the MSB so both the carry into and out of bit 15 are
    // visible, matching the ripple chain; SUB is a + ~b + 1.
    always_comb begin
        is_sub     = (bus.alu_ctrl == OP_SUB);
        b_op       = is_sub ? ~bus.b : bus.b;
        low_sum    = {1'b0, bus.a[WIDTH-2:0]} + {1'b0, b_op[WIDTH-2:0]}
                     + {{(WIDTH-1){1'b0}}, is_sub};
        c_into_msb = low_sum[WIDTH-1];
        top_sum    = {1'b0, bus.a[WIDTH-1]} + {1'b0, b_op[WIDTH-1]} + {1'b0, c_into_msb};
        arith_sum  = {top_sum[0], low_sum[WIDTH-2:0]};
    end

    // Operation select; carries only reported for ADD/SUB.
    always_comb begin
        result            = '0;
        carry_second_last = 1'b0;
        carry_last        = 1'b0;
        case (bus.alu_ctrl)
            OP_ADD, OP_SUB: begin
                result            = arith_sum;
                carry_second_last = c_into_msb;
                carry_last        = top_sum[1];
            end
            OP_AND:  result = bus.a & bus.b;
            OP_OR:   result = bus.a | bus.b;
            OP_XOR:  result = bus.a ^ bus.b;
            OP_NOT:  result = ~bus.b;
            OP_SHL:  result = {bus.a[WIDTH-2:0], 1'b0};
            OP_PASS: result = bus.b;
            default: result = '0;
        endcase
        zero_next = (result == '0);
        ovf_next  = carry_second_last ^ carry_last;
    end

    // Flag bank: reset wins, otherwise each flag loads only under its own enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_m_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_o_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            if (bus.m_we) flag_m_q <= result[WIDTH-1];
            if (bus.z_we) flag_z_q <= zero_next;
            if (bus.o_we) flag_o_q <= ovf_next;
            if (bus.c_we) flag_c_q <= carry_last;
        end
    end

    // Jump test looks only at registered flags, never at the *_next values.
    always_comb begin
        sel_flag = 1'b0;
        case (bus.jump_sel)
            2'b00:   sel_flag = flag_m_q;
            2'b01:   sel_flag = flag_z_q;
            2'b10:   sel_flag = flag_o_q;
            2'b11:   sel_flag = flag_c_q;
            default: sel_flag = 1'b0;
        endcase
    end

    assign bus.result            = result;
    assign bus.carry_second_last = carry_second_last;
    assign bus.carry_last        = carry_last;
    assign bus.zero_next         = zero_next;
    assign bus.ovf_next          = ovf_next;
    assign bus.flag_m            = flag_m_q;
    assign bus.flag_z            = flag_z_q;
    assign bus.flag_o            = flag_o_q;
    assign bus.flag_c            = flag_c_q;
    assign bus.flag_m_n          = ~flag_m_q;
    assign bus.flag_z_n          = ~flag_z_q;
    assign bus.flag_o_n          = ~flag_o_q;
    assign bus.flag_c_n          = ~flag_c_q;
    assign bus.jump_true         = ~(bus.jump_pol ^ sel_flag);
endmodule

// File: tb/tb_alu_flag_unit.sv
// Bench for alu_flag_unit: directed vectors push hand-computed expectations
// into a queue; a monitor on the falling edge pops and compares.
module tb_alu_flag_unit;
    logic clk = 1'b0;
    logic reset;

    alu_flag_unit_if #(.WIDTH(16)) bus ();

    alu_flag_unit #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic        csl;
        logic        cl;
        logic        zn;
        logic        on;
        bit          chk_flags;
        logic [3:0]  flg;   // {M, Z, O, C}
        logic        jt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input string what,
                       input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", name, what, act, exp);
        end
    endtask

    // Monitor: inputs change 1 time unit after a rising edge, so the falling
    // edge sees settled combinational outputs and the flags from that edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "result", bus.result, e.res);
            chk(e.name, "carry_second_last", {15'd0, bus.carry_second_last}, {15'd0, e.csl});
            chk(e.name, "carry_last", {15'd0, bus.carry_last}, {15'd0, e.cl});
            chk(e.name, "zero_next", {15'd0, bus.zero_next}, {15'd0, e.zn});
            chk(e.name, "ovf_next", {15'd0, bus.ovf_next}, {15'd0, e.on});
            if (e.chk_flags) begin
                chk(e.name, "flags", {12'd0, bus.flag_m, bus.flag_z, bus.flag_o, bus.flag_c},
                    {12'd0, e.flg});
                chk(e.name, "flags_n",
                    {12'd0, bus.flag_m_n, bus.flag_z_n, bus.flag_o_n, bus.flag_c_n},
                    {12'd0, ~e.flg});
                chk(e.name, "jump_true", {15'd0, bus.jump_true}, {15'd0, e.jt});
            end
        end
    end

    task automatic step(input string name, input logic rst, input logic [2:0] ctrl,
                        input logic [15:0] a, input logic [15:0] b, input logic [3:0] we,
                        input logic [1:0] jsel, input logic jpol,
                        input logic [15:0] eres, input logic ecsl, input logic ecl,
                        input logic ezn, input logic eon,
                        input bit cflg, input logic [3:0] eflg, input logic ejt);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.alu_ctrl = ctrl;
        bus.a        = a;
        bus.b        = b;
        {bus.m_we, bus.z_we, bus.o_we, bus.c_we} = we;
        bus.jump_sel = jsel;
        bus.jump_pol = jpol;
        e.name = name; e.res = eres; e.csl = ecsl; e.cl = ecl; e.zn = ezn; e.on = eon;
        e.chk_flags = cflg; e.flg = eflg; e.jt = ejt;
        sb.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        bus.alu_ctrl = 3'b000; bus.a = '0; bus.b = '0;
        {bus.m_we, bus.z_we, bus.o_we, bus.c_we} = 4'b0000;
        bus.jump_sel = 2'b00; bus.jump_pol = 1'b0;

        // Flag expectations are the state left by the previous rising edge.
        //    name        rst ctrl    a        b        we      js    jp    res      csl cl zn on  cf flg     jt
        step("rst_hold",  1, 3'b000, 16'h0000, 16'h0002, 4'b0000, 2'b00, 1'b0, 16'h0002, 0, 0, 0, 0, 0, 4'b0000, 0);
        step("pc_inc0",   0, 3'b000, 16'h0000, 16'h0002, 4'b0000, 2'b00, 1'b0, 16'h0002, 0, 0, 0, 0, 1, 4'b0000, 1);
        step("pc_inc1",   0, 3'b000, 16'h0002, 16'h0002, 4'b0000, 2'b00, 1'b1, 16'h0004, 0, 0, 0, 0, 1, 4'b0000, 0);
        step("add_ovf",   0, 3'b000, 16'h7FFF, 16'h0001, 4'b1111, 2'b00, 1'b0, 16'h8000, 1, 0, 0, 1, 1, 4'b0000, 1);
        step("add_wrap",  0, 3'b000, 16'hFFFF, 16'h0001, 4'b1111, 2'b00, 1'b1, 16'h0000, 1, 1, 1, 0, 1, 4'b1010, 1);
        step("sub_eq",    0, 3'b001, 16'h0005, 16'h0005, 4'b1111, 2'b11, 1'b1, 16'h0000, 1, 1, 1, 0, 1, 4'b0101, 1);
        step("sub_borrow",0, 3'b001, 16'h0003, 16'h0005, 4'b1111, 2'b01, 1'b1, 16'hFFFE, 0, 0, 0, 0, 1, 4'b0101, 1);
        step("and",       0, 3'b010, 16'h0F0F, 16'h00FF, 4'b0000, 2'b00, 1'b1, 16'h000F, 0, 0, 0, 0, 1, 4'b1000, 1);
        step("or",        0, 3'b011, 16'h0F0F, 16'h00FF, 4'b0000, 2'b11, 1'b0, 16'h0FFF, 0, 0, 0, 0, 1, 4'b1000, 1);
        step("xor",       0, 3'b100, 16'h0F0F, 16'h00FF, 4'b0000, 2'b10, 1'b1, 16'h0FF0, 0, 0, 0, 0, 1, 4'b1000, 0);
        step("not",       0, 3'b101, 16'h0F0F, 16'h00FF, 4'b0000, 2'b00, 1'b1, 16'hFF00, 0, 0, 0, 0, 1, 4'b1000, 1);
        step("shl",       0, 3'b110, 16'h0F0F, 16'h00FF, 4'b0000, 2'b00, 1'b1, 16'h1E1E, 0, 0, 0, 0, 1, 4'b1000, 1);
        step("pass",      0, 3'b111, 16'h0F0F, 16'h00FF, 4'b0000, 2'b00, 1'b1, 16'h00FF, 0, 0, 0, 0, 1, 4'b1000, 1);
        step("set_z",     0, 3'b000, 16'h0000, 16'h0000, 4'b1111, 2'b00, 1'b1, 16'h0000, 0, 0, 1, 0, 1, 4'b1000, 1);
        step("jz_pol1",   0, 3'b111, 16'h0000, 16'h1234, 4'b0000, 2'b01, 1'b1, 16'h1234, 0, 0, 0, 0, 1, 4'b0100, 1);
        step("jz_pol0",   0, 3'b111, 16'h0000, 16'h1234, 4'b0000, 2'b01, 1'b0, 16'h1234, 0, 0, 0, 0, 1, 4'b0100, 0);
        step("jc_pol0",   0, 3'b111, 16'h0000, 16'h1234, 4'b0000, 2'b11, 1'b0, 16'h1234, 0, 0, 0, 0, 1, 4'b0100, 1);
        step("we_m_o",    0, 3'b000, 16'h7FFF, 16'h0001, 4'b1010, 2'b00, 1'b0, 16'h8000, 1, 0, 0, 1, 1, 4'b0100, 1);
        step("we_c",      0, 3'b000, 16'hFFFF, 16'h0001, 4'b0001, 2'b10, 1'b1, 16'h0000, 1, 1, 1, 0, 1, 4'b1110, 1);
        step("rst_mid",   1, 3'b000, 16'hFFFF, 16'h0001, 4'b1111, 2'b11, 1'b1, 16'h0000, 1, 1, 1, 0, 1, 4'b1111, 1);
        step("rst_done0", 0, 3'b111, 16'h0000, 16'h0000, 4'b0000, 2'b00, 1'b0, 16'h0000, 0, 0, 1, 0, 1, 4'b0000, 1);
        step("rst_done1", 0, 3'b111, 16'h0000, 16'h0000, 4'b0000, 2'b11, 1'b1, 16'h0000, 0, 0, 1, 0, 1, 4'b0000, 0);

        // Give the monitor a bounded number of cycles to drain the queue.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
